// File: rtl/dequant_pkg.sv
// rtl/dequant_pkg.sv - shared constants, types and clamp limits for the dequantizer
package dequant_pkg;

  localparam int BLK_N  = 64;
  localparam int IDX_W  = $clog2(BLK_N);
  localparam int STEP_W = 16;

  typedef logic [STEP_W-1:0] step_t;
  typedef logic [IDX_W-1:0]  idx_t;

  // Largest value representable in a w-bit two's complement word.
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/dequant_mul_sat.sv
// rtl/dequant_mul_sat.sv - signed coefficient times unsigned step, clamped to IN_W
module dequant_mul_sat #(
  parameter int IN_W   = 32,
  parameter int STEP_W = 16
) (
  input  logic [IN_W-1:0]   coef,
  input  logic [STEP_W-1:0] step,
  output logic [IN_W-1:0]   data,
  output logic              sat
);
  import dequant_pkg::*;

  localparam int P_W = IN_W + STEP_W + 1;
  localparam logic signed [P_W-1:0] P_MAX = P_W'(sat_max(IN_W));
  localparam logic signed [P_W-1:0] P_MIN = P_W'(sat_min(IN_W));
  localparam logic [IN_W-1:0]       O_MAX = IN_W'(sat_max(IN_W));
  localparam logic [IN_W-1:0]       O_MIN = IN_W'(sat_min(IN_W));

  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] b_ext;
  (* use_dsp = "no" *) logic signed [P_W-1:0] p;

  // Both operands widened to the full product width so the low P_W bits are exact.
  assign a_ext = {{(STEP_W + 1){coef[IN_W-1]}}, coef};
  assign b_ext = {{(IN_W + 1){1'b0}}, step};
  assign p     = a_ext * b_ext;

  always_comb begin
    data = p[IN_W-1:0];
    sat  = 1'b0;
    if (p > P_MAX) begin
      data = O_MAX;
      sat  = 1'b1;
    end else if (p < P_MIN) begin
      data = O_MIN;
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/lut_dequantizer_stream.sv
// rtl/lut_dequantizer_stream.sv - 2-stage stall-all dequantizer with writable 64-entry step table
module lut_dequantizer_stream #(
  parameter int IN_W   = 32,
  parameter int STEP_W = dequant_pkg::STEP_W,
  parameter int BLK_N  = dequant_pkg::BLK_N
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [IN_W-1:0]        s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [IN_W-1:0]        m_data,
  output logic                   m_last,
  output logic                   m_sat,
  input  logic                   tbl_we,
  input  dequant_pkg::idx_t      tbl_addr,
  input  logic [STEP_W-1:0]      tbl_data,
  output logic                   tbl_err,
  output logic                   busy
);
  import dequant_pkg::*;

  localparam int IW = $clog2(BLK_N);

  logic [IW-1:0]     idx;
  logic [STEP_W-1:0] tbl [BLK_N];

  logic              s1_valid;
  logic              s1_last;
  logic [IN_W-1:0]   s1_data;
  logic [STEP_W-1:0] s1_step;

  logic              advance;
  logic              accept;
  logic              wr_ok;
  logic [IN_W-1:0]   mul_data;
  logic              mul_sat;

  assign advance = !m_valid || m_ready;
  assign s_ready = advance;
  assign accept  = s_valid && advance;
  assign busy    = (idx != '0) || s1_valid || m_valid;
  // An accept in this cycle starts a block, so it blocks the write just like busy does.
  assign wr_ok   = tbl_we && !busy && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLK_N; i++) tbl[i] <= STEP_W'(1);
    end else if (wr_ok) begin
      tbl[tbl_addr] <= tbl_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      tbl_err  <= 1'b0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
      s1_step  <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      m_sat    <= 1'b0;
    end else begin
      tbl_err <= tbl_we && !wr_ok;
      if (accept) idx <= idx + IW'(1);
      if (advance) begin
        s1_valid <= accept;
        if (accept) begin
          s1_data <= s_data;
          s1_step <= tbl[idx];
          s1_last <= (idx == IW'(BLK_N - 1));
        end
        m_valid <= s1_valid;
        m_data  <= s1_valid ? mul_data : '0;
        m_last  <= s1_valid && s1_last;
        m_sat   <= s1_valid && mul_sat;
      end
    end
  end

  dequant_mul_sat #(
    .IN_W   (IN_W),
    .STEP_W (STEP_W)
  ) u_mul_sat (
    .coef (s1_data),
    .step (s1_step),
    .data (mul_data),
    .sat  (mul_sat)
  );

endmodule

// File: tb/tb_lut_dequantizer_stream.sv
// tb/tb_lut_dequantizer_stream.sv - randomized scoreboard bench for lut_dequantizer_stream
module tb_lut_dequantizer_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_sat;
  logic        tbl_we;
  logic [5:0]  tbl_addr;
  logic [15:0] tbl_data;
  logic        tbl_err;
  logic        busy;

  always #5 clk = ~clk;

  lut_dequantizer_stream #(.IN_W(32), .STEP_W(16), .BLK_N(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .m_sat(m_sat),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .tbl_err(tbl_err), .busy(busy)
  );

  typedef struct { logic [31:0] d; bit last; bit sat; } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  logic [31:0] pend[$];
  int          mtbl[64];
  int          mdl_idx = 0;
  bit          pend_err = 0;
  bit          hold_v = 0;
  logic [31:0] hold_d;
  bit          acc;
  bit          inj_en = 0;
  int          inj_idx, inj_addr, inj_data;
  bit          saw_sready_low;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic exp_t model_beat(input logic [31:0] d, input int step, input bit last);
    exp_t   e;
    longint p;
    p = longint'($signed(d)) * longint'(step);
    e.last = last;
    if (p > 64'sd2147483647) begin
      e.d = 32'h7FFF_FFFF; e.sat = 1;
    end else if (p < -64'sd2147483648) begin
      e.d = 32'h8000_0000; e.sat = 1;
    end else begin
      e.d = p[31:0]; e.sat = 0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(2))
      0:       return $urandom;
      1:       return 32'(int'($urandom_range(2000)) - 1000);
      default: return 32'(int'($urandom_range(400000)) - 200000);
    endcase
  endfunction

  // One clock: check outputs at the falling edge, predict the coming rising edge, then step.
  task automatic cycle();
    bit   mbusy;
    exp_t e;
    @(negedge clk);
    mbusy = (mdl_idx != 0) || (exp_q.size() != 0);
    chk("busy", busy, mbusy);
    chk("tbl_err", tbl_err, pend_err);
    if (hold_v) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, hold_d);
    end
    hold_v = m_valid && !m_ready;
    hold_d = m_data;
    if (m_valid && m_ready) begin
      chk("spurious_beat", exp_q.size() == 0, 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("m_data", m_data, e.d);
        chk("m_last", m_last, e.last);
        chk("m_sat", m_sat, e.sat);
      end
    end
    acc = s_valid && s_ready;
    pend_err = 0;
    if (tbl_we) begin
      if (mbusy || acc) pend_err = 1;
      else mtbl[tbl_addr] = int'(tbl_data);
    end
    if (acc) begin
      exp_q.push_back(model_beat(s_data, mtbl[mdl_idx], mdl_idx == 63));
      mdl_idx = (mdl_idx + 1) % 64;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input int vpct, input int rpct, input int stall_at);
    int n = 0;
    int stall_cnt = 0;
    bit stall_done = 0;
    saw_sready_low = 0;
    while (pend.size() > 0 && n < 3000) begin
      s_valid = ($urandom_range(99) < vpct);
      s_data  = pend[0];
      m_ready = ($urandom_range(99) < rpct);
      tbl_we  = 0;
      if (!stall_done && mdl_idx == stall_at) begin
        stall_cnt = 5; stall_done = 1;
      end
      if (stall_cnt > 0) begin
        m_ready = 0; stall_cnt--;
      end
      if (inj_en && s_valid && mdl_idx == inj_idx) begin
        tbl_we = 1; tbl_addr = 6'(inj_addr); tbl_data = 16'(inj_data); inj_en = 0;
      end
      cycle();
      if (stall_cnt > 0 && !s_ready) saw_sready_low = 1;
      if (acc) void'(pend.pop_front());
      n++;
    end
    chk("stream_timeout", pend.size(), 0);
    s_valid = 0;
    tbl_we  = 0;
  endtask

  task automatic drain();
    int n = 0;
    s_valid = 0;
    m_ready = 1;
    while (exp_q.size() != 0 && n < 50) begin
      cycle(); n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    cycle();
  endtask

  task automatic write_tbl(input int addr, input int val);
    s_valid = 0; tbl_we = 1; tbl_addr = 6'(addr); tbl_data = 16'(val);
    cycle();
    tbl_we = 0;
  endtask

  task automatic queue_random(input int n);
    for (int i = 0; i < n; i++) pend.push_back(rnd_data());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mtbl[i] = 1;
    rst_n = 0; s_valid = 1; s_data = 'x; m_ready = 1;
    tbl_we = 0; tbl_addr = 0; tbl_data = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_sat", m_sat, 0);
    chk("rst_tbl_err", tbl_err, 0);
    chk("rst_busy", busy, 0);
    s_valid = 0; rst_n = 1;
    cycle();

    // Identity table, full rate, latency of two cycles from accept to m_valid.
    s_valid = 1; s_data = 32'(-5); m_ready = 1;
    cycle();
    chk("lat_cycle1", m_valid, 0);
    s_data = 32'd0;
    cycle();
    chk("lat_cycle2", m_valid, 1);
    pend.push_back(32'd7);
    queue_random(61);
    run_stream(100, 100, -1);
    drain();

    // Loaded table, two blocks so the index wraps back onto entry 0.
    write_tbl(0, 16);
    write_tbl(1, 11);
    write_tbl(63, 99);
    for (int b = 0; b < 2; b++) begin
      pend.push_back(32'd3);
      pend.push_back(32'(-2));
      for (int i = 2; i < 63; i++) pend.push_back(32'(int'($urandom_range(200)) - 100));
      pend.push_back(32'(-4));
    end
    run_stream(100, 100, -1);
    drain();

    // Five cycles of backpressure in the middle of a block.
    queue_random(64);
    run_stream(100, 100, 20);
    chk("bp_sready_low", saw_sready_low, 1);
    drain();

    // Clamping at both rails and a zero step.
    write_tbl(0, 2);
    write_tbl(1, 2);
    write_tbl(2, 0);
    pend.push_back(32'h7FFF_FFFF);
    pend.push_back(32'h8000_0000);
    pend.push_back(32'h0012_3456);
    queue_random(61);
    run_stream(100, 100, -1);
    drain();

    // A write mid-block is rejected; the next block still uses the old entry.
    inj_en = 1; inj_idx = 10; inj_addr = 5; inj_data = 777;
    queue_random(64);
    run_stream(100, 100, -1);
    chk("inj_consumed", inj_en, 0);
    drain();
    queue_random(64);
    run_stream(100, 100, -1);
    drain();
    write_tbl(5, 777);
    cycle();

    // Random table contents, random valid and ready patterns.
    for (int i = 0; i < 64; i++)
      write_tbl(i, ($urandom_range(7) == 0) ? 0 : int'($urandom_range(65535)));
    queue_random(128);
    run_stream(70, 60, -1);
    drain();

    // Asynchronous reset at index 30 with two beats in flight.
    queue_random(28);
    run_stream(100, 100, -1);
    drain();
    queue_random(2);
    run_stream(100, 0, -1);
    chk("pre_rst_idx", mdl_idx, 30);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    exp_q.delete();
    mdl_idx = 0; pend_err = 0; hold_v = 0;
    for (int i = 0; i < 64; i++) mtbl[i] = 1;
    s_valid = 1; s_data = 'x;
    repeat (2) @(posedge clk);
    #1;
    s_valid = 0; m_ready = 1; rst_n = 1;
    cycle();
    chk("post_rst_m_valid", m_valid, 0);
    queue_random(64);
    run_stream(90, 80, -1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_dequantizer_stream.md
Name: lut_dequantizer_stream

Overview:
- Inverse of the quantization stage. Consumes a stream of quantized DCT coefficients in block order, 64 per 8x8 block, in the order the quantizer emits them.
- Multiplies each coefficient by the quantization step for its position, then emits the reconstructed coefficient stream toward the IDCT.
- Holds a writable 64-entry step table and a 2-stage stall-all pipeline with valid/ready on both sides.
- Multiplier is LUT-based, no DSP, same as the forward quantizer.

Parameters:
- IN_W, 32, coefficient data width, signed, input and output.
- STEP_W, 16, quantization step width, unsigned.
- BLK_N, 64, coefficients per block. Must be a power of two.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input coefficient valid.
- s_ready  out  1  input accepted when s_valid && s_ready.
- s_data  in  IN_W  quantized coefficient, signed.
- m_valid  out  1  output coefficient valid.
- m_ready  in  1  downstream accepts output.
- m_data  out  IN_W  dequantized coefficient, signed, saturated.
- m_last  out  1  high on the 64th coefficient of a block.
- m_sat  out  1  this beat was clamped.
- tbl_we  in  1  step table write strobe.
- tbl_addr  in  6  table index, 0..63.
- tbl_data  in  STEP_W  step value.
- tbl_err  out  1  one-cycle pulse when a write is rejected.
- busy  out  1  block in progress or pipeline not empty.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - m_valid=0, m_data=0, m_last=0, m_sat=0, tbl_err=0, busy=0.
  - Position index idx=0.
  - All table entries = 1, i.e. identity.
  - Reset mid-block discards all in-flight data; the next accepted beat is position 0.
- Pipeline:
  - advance = !m_valid || m_ready.
  - s_ready = advance.
  - Stage 1 registers s_data, tbl[idx], and last=(idx==BLK_N-1) on accept.
  - Stage 2 registers the product.
  - Latency: accept in cycle N gives m_valid in cycle N+2 when there is no stall.
  - Throughput: 1 beat/cycle.
  - With m_ready held low, no stage changes and m_data stays stable until accepted.
- Index:
  - idx increments on each accepted input.
  - Wraps from 63 to 0; no gap cycle at block boundaries.
- Arithmetic:
  - p = s_data (signed) * zero-extended step, full width IN_W+STEP_W+1.
  - No shift: the step is an integer.
  - If p > 2^(IN_W-1)-1, output 2^(IN_W-1)-1 and set m_sat=1.
  - If p < -2^(IN_W-1), output -2^(IN_W-1) and set m_sat=1.
  - Otherwise output p[IN_W-1:0] with m_sat=0.
  - step=0 gives 0.
- Table writes:
  - Accepted only when busy=0. busy = (idx!=0) || stage1 valid || m_valid.
  - A write while busy=1 is dropped and tbl_err=1 for the next cycle.
  - A write in the same cycle as the first input accept (idx=0) is dropped with tbl_err, because the accept makes the block busy.
  - The table is read combinationally at stage 1, so a write accepted in cycle N affects inputs accepted in cycle N+1 and later.
- Simultaneous events:
  - Output accept and input accept in the same cycle: both complete, and the pipeline shifts.
  - m_last on beat 63 and the beat-0 input of the next block in the same cycle are both legal.
- Edge case: s_valid high with data X during reset must not propagate.

Decomposition:
- Package dequant_pkg holds:
  - BLK_N, IDX_W=$clog2(BLK_N), STEP_W defaults.
  - The sat_min/sat_max constants as functions of IN_W.
  - typedef step_t (logic [STEP_W-1:0]).
  - typedef idx_t.
- One sub-module: dequant_mul_sat. It is a combinational signed × unsigned LUT multiply (use_dsp="no") plus the clamp, with outputs {data, sat}, instantiated at stage 2.
- Table, index counter and pipeline control stay in the top.

Test Plan:
- Identity after reset: stream s_data = -5, 0, 7, ... for 64 beats -> m_data equals input, m_last only on beat 64, first m_valid 2 cycles after first accept.
- Loaded table: write tbl[0]=16, tbl[1]=11, tbl[63]=99 while idle, then send 3, -2, ..., beat 63 = -4 -> 48, -22, ..., -396. Repeat for a second block to check the index wrap.
- Backpressure: m_ready low for 5 cycles mid-block -> s_ready low after the pipeline fills, m_data held stable, no beat lost or duplicated, order preserved.
- Saturation with IN_W=32: s_data=0x7FFF_FFFF with step 2 -> 0x7FFF_FFFF, m_sat=1. s_data=0x8000_0000 with step 2 -> 0x8000_0000, m_sat=1. step 0 -> 0, m_sat=0.
- Rejected write: tbl_we at idx=10 -> tbl_err pulse, table unchanged, verified on the next block. A write after the block drains -> accepted, tbl_err=0.
- Reset mid-block: assert rst_n=0 at idx=30 with 2 beats in flight -> m_valid=0 immediately, busy=0. After release, the next input uses tbl[0] and the table is back to all 1s.
